// File: rtl/tb_mbox_pkg.sv
// Shared encodings and defaults for the LSU mailbox console/end-of-test monitor.
// Also holds the payload classifier used by the monitor's decode stage.
package tb_mbox_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [31:0] MBOX_ADDR_DEFAULT  = 32'hD058_0000;
    localparam logic [31:0] TIMEOUT_DEFAULT    = 32'h0000_1800;
    localparam logic [7:0]  PASS_CODE_DEFAULT  = 8'hFF;
    localparam logic [7:0]  FAIL_CODE_DEFAULT  = 8'h01;
    localparam int          FIFO_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        DEC_NONE,
        DEC_CHAR,
        DEC_PASS,
        DEC_FAIL
    } dec_e;

    function automatic dec_e classify(input logic [7:0] b,
                                      input logic [7:0] pass_code,
                                      input logic [7:0] fail_code);
        if (b == pass_code) return DEC_PASS;
        if (b == fail_code) return DEC_FAIL;
        return DEC_CHAR;
    endfunction

endpackage

// File: rtl/tb_sync_fifo.sv
// Show-ahead synchronous FIFO: head word is visible combinationally while not empty.
// A push into a full FIFO is accepted only when a pop happens on the same cycle.
module tb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     core_clk,
    input  logic                     reset_l,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_acc, pop_acc;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CW'(DEPTH));
    assign pop_acc  = pop_i & ~empty_o;
    assign push_acc = push_i & (~full_o | pop_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge core_clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge core_clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tb_mailbox_mon.sv
// Snoops LSU AHB-Lite writes to the mailbox byte address: printable bytes go to a
// console FIFO, pass/fail codes (or a cycle timeout) latch the end-of-test status.
module tb_mailbox_mon
    import tb_mbox_pkg::*;
#(
    parameter logic [31:0] MBOX_ADDR      = MBOX_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH     = FIFO_DEPTH_DEFAULT,
    parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter logic [7:0]  PASS_CODE      = PASS_CODE_DEFAULT,
    parameter logic [7:0]  FAIL_CODE      = FAIL_CODE_DEFAULT
) (
    input  logic                          core_clk,
    input  logic                          reset_l,
    input  logic [31:0]                   haddr,
    input  logic [1:0]                    htrans,
    input  logic                          hwrite,
    input  logic [2:0]                    hsize,
    input  logic [63:0]                   hwdata,
    input  logic                          hready,
    output logic                          char_valid,
    output logic [7:0]                    char_data,
    input  logic                          char_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          test_done,
    output logic                          test_pass,
    output logic                          timeout,
    output logic [31:0]                   done_cycle
);
    logic        pending_q, pending_d;
    logic [2:0]  lane_q, lane_d;
    logic        byte_vld_q, byte_vld_d;
    logic [7:0]  byte_q, byte_d;
    logic [31:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        tmo_q, tmo_d;
    logic        ovf_q, ovf_d;
    logic [31:0] done_cyc_q, done_cyc_d;

    logic        addr_hit;
    logic [7:0]  lane_bytes [8];
    dec_e        dec;
    logic        push, pop, code_hit;
    logic        fifo_full, fifo_empty;
    logic        unused_bus;

    // Transfer size and the SEQ/NONSEQ distinction do not affect byte extraction.
    assign unused_bus = ^{hsize, htrans[0]};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_bytes[gi] = hwdata[8*gi +: 8];
        end
    endgenerate

    assign addr_hit = hready & htrans[1] & hwrite & (haddr[31:3] == MBOX_ADDR[31:3]);

    // A data phase completes on the same edge that may accept the next address phase.
    always_comb begin
        pending_d  = pending_q;
        lane_d     = lane_q;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        if (hready) begin
            if (pending_q) begin
                byte_vld_d = 1'b1;
                byte_d     = lane_bytes[lane_q];
            end
            pending_d = addr_hit;
            if (addr_hit) lane_d = haddr[2:0];
        end
    end

    assign dec      = classify(byte_q, PASS_CODE, FAIL_CODE);
    assign push     = byte_vld_q & ~done_q & (dec == DEC_CHAR);
    assign code_hit = byte_vld_q & ~done_q & ((dec == DEC_PASS) | (dec == DEC_FAIL));
    assign pop      = char_valid & char_ready;

    always_comb begin
        cnt_d      = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        done_d     = done_q;
        pass_d     = pass_q;
        tmo_d      = tmo_q;
        done_cyc_d = done_cyc_q;
        ovf_d      = ovf_q | (push & fifo_full & ~pop);
        // A code decoded on the timeout cycle takes priority over the timeout.
        if (!done_q) begin
            if (code_hit) begin
                done_d     = 1'b1;
                pass_d     = (dec == DEC_PASS);
                done_cyc_d = cnt_q;
            end else if ((TIMEOUT_CYCLES != 32'd0) && (cnt_q == TIMEOUT_CYCLES)) begin
                done_d     = 1'b1;
                pass_d     = 1'b0;
                tmo_d      = 1'b1;
                done_cyc_d = cnt_q;
            end
        end
    end

    always_ff @(posedge core_clk or negedge reset_l) begin
        if (!reset_l) begin
            pending_q  <= 1'b0;
            lane_q     <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            tmo_q      <= 1'b0;
            ovf_q      <= 1'b0;
            done_cyc_q <= '0;
        end else begin
            pending_q  <= pending_d;
            lane_q     <= lane_d;
            byte_vld_q <= byte_vld_d;
            byte_q     <= byte_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            tmo_q      <= tmo_d;
            ovf_q      <= ovf_d;
            done_cyc_q <= done_cyc_d;
        end
    end

    tb_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (core_clk),
        .reset_l  (reset_l),
        .push_i   (push),
        .din_i    (byte_q),
        .pop_i    (pop),
        .dout_o   (char_data),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    assign char_valid = ~fifo_empty;
    assign overflow   = ovf_q;
    assign test_done  = done_q;
    assign test_pass  = pass_q;
    assign timeout    = tmo_q;
    assign done_cycle = done_cyc_q;

endmodule

// File: tb/tb_tb_mailbox_mon.sv
// Directed bench for the mailbox monitor: console bytes, lanes, wait states, FIFO
// overflow, pass/fail codes, timeout and reset during a pending data phase.
module tb_tb_mailbox_mon;
    import tb_mbox_pkg::*;

    localparam logic [31:0] MBOX = 32'hD058_0000;

    logic        core_clk = 1'b0;
    logic        reset_l;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [63:0] hwdata;
    logic        hready;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        test_done;
    logic        test_pass;
    logic        timeout;
    logic [31:0] done_cycle;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] cyc;

    tb_mailbox_mon dut (
        .core_clk   (core_clk),
        .reset_l    (reset_l),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hwdata     (hwdata),
        .hready     (hready),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .test_done  (test_done),
        .test_pass  (test_pass),
        .timeout    (timeout),
        .done_cycle (done_cycle)
    );

    always #5 core_clk = ~core_clk;

    // Reference cycle count: clock edges since reset release, saturating.
    always @(posedge core_clk or negedge reset_l) begin
        if (!reset_l) cyc <= 32'd0;
        else if (cyc != 32'hFFFF_FFFF) cyc <= cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge core_clk);
            htrans = HTRANS_IDLE;
            hwrite = 1'b0;
            hready = 1'b1;
        end
    endtask

    // Returns with the data phase driven; the data edge is the next posedge.
    task automatic ahb_xfer(input logic [31:0] a, input logic [63:0] d,
                            input int waits, input logic wr);
        @(negedge core_clk);
        haddr  = a;
        htrans = HTRANS_NONSEQ;
        hwrite = wr;
        hready = 1'b1;
        @(negedge core_clk);
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        haddr  = 32'd0;
        hwdata = d;
        hready = (waits == 0);
        for (int i = 0; i < waits; i++) begin
            @(negedge core_clk);
            hready = (i == waits - 1);
        end
    endtask

    // Back-to-back lane-0 writes, one per cycle, payload base+i.
    task automatic burst(input int n, input logic [7:0] base);
        for (int i = 0; i <= n; i++) begin
            @(negedge core_clk);
            hready = 1'b1;
            if (i < n) begin
                haddr  = MBOX;
                htrans = HTRANS_SEQ;
                hwrite = 1'b1;
            end else begin
                htrans = HTRANS_IDLE;
                hwrite = 1'b0;
            end
            if (i > 0) hwdata = {56'd0, base + 8'(i - 1)};
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_l    = 1'b0;
        haddr      = 32'd0;
        htrans     = HTRANS_IDLE;
        hwrite     = 1'b0;
        hsize      = 3'd0;
        hwdata     = 64'd0;
        hready     = 1'b1;
        char_ready = 1'b0;
        repeat (3) @(negedge core_clk);
        chk("rst_valid", 64'(char_valid), 64'd0);
        chk("rst_data", 64'(char_data), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_done", 64'(test_done), 64'd0);
        chk("rst_pass", 64'(test_pass), 64'd0);
        chk("rst_tmo", 64'(timeout), 64'd0);
        chk("rst_dcyc", 64'(done_cycle), 64'd0);
        reset_l = 1'b1;

        // "Hi" to lane 0, then drain
        ahb_xfer(MBOX, 64'h48, 0, 1'b1);
        ahb_xfer(MBOX, 64'h69, 0, 1'b1);
        idle(2);
        chk("hi_count", 64'(fifo_count), 64'd2);
        chk("hi_valid", 64'(char_valid), 64'd1);
        chk("hi_head0", 64'(char_data), 64'h48);
        char_ready = 1'b1;
        idle(1);
        chk("hi_head1", 64'(char_data), 64'h69);
        chk("hi_count1", 64'(fifo_count), 64'd1);
        idle(1);
        char_ready = 1'b0;
        chk("hi_count0", 64'(fifo_count), 64'd0);
        chk("hi_valid0", 64'(char_valid), 64'd0);

        // lane 3 with two wait states
        ahb_xfer(32'hD058_0003, 64'h0000_0000_4100_0000, 2, 1'b1);
        idle(1);
        chk("ln3_latency", 64'(fifo_count), 64'd0);
        idle(1);
        chk("ln3_count", 64'(fifo_count), 64'd1);
        chk("ln3_data", 64'(char_data), 64'h41);
        idle(2);
        chk("ln3_once", 64'(fifo_count), 64'd1);
        char_ready = 1'b1;
        idle(1);
        char_ready = 1'b0;
        chk("ln3_drain", 64'(fifo_count), 64'd0);

        // 17 chars into a 16-deep FIFO
        burst(17, 8'h30);
        idle(2);
        chk("ovf_count", 64'(fifo_count), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_head", 64'(char_data), 64'h30);
        ahb_xfer(MBOX, 64'h5A, 0, 1'b1);
        idle(1);
        char_ready = 1'b1;
        idle(1);
        char_ready = 1'b0;
        chk("full_pp_count", 64'(fifo_count), 64'd16);
        chk("full_pp_head", 64'(char_data), 64'h31);
        char_ready = 1'b1;
        idle(15);
        char_ready = 1'b0;
        chk("tail_data", 64'(char_data), 64'h5A);
        chk("tail_count", 64'(fifo_count), 64'd1);

        // reset while a data phase is stalled
        @(negedge core_clk);
        haddr = MBOX; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hready = 1'b1;
        @(negedge core_clk);
        htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = 64'h77; hready = 1'b0;
        @(negedge core_clk);
        reset_l = 1'b0;
        #1;
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_valid", 64'(char_valid), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        chk("mid_rst_data", 64'(char_data), 64'd0);
        @(negedge core_clk);
        reset_l = 1'b1;
        hready  = 1'b1;
        idle(3);
        chk("post_rst_count", 64'(fifo_count), 64'd0);
        chk("post_rst_done", 64'(test_done), 64'd0);

        // PASS code decoded at cycle 100
        while (cyc != 32'd97) @(negedge core_clk);
        ahb_xfer(MBOX, 64'hFF, 0, 1'b1);
        idle(1);
        chk("pass_latency", 64'(test_done), 64'd0);
        idle(1);
        chk("pass_done", 64'(test_done), 64'd1);
        chk("pass_pass", 64'(test_pass), 64'd1);
        chk("pass_dcyc", 64'(done_cycle), 64'd100);
        chk("pass_tmo", 64'(timeout), 64'd0);
        ahb_xfer(MBOX, 64'h42, 0, 1'b1);
        idle(3);
        chk("after_done_cnt", 64'(fifo_count), 64'd0);
        chk("after_done_dc", 64'(done_cycle), 64'd100);

        // address/direction filtering, then timeout
        @(negedge core_clk); reset_l = 1'b0;
        @(negedge core_clk); reset_l = 1'b1;
        ahb_xfer(32'hD058_0008, 64'h55, 0, 1'b1);
        idle(3);
        chk("wrong_addr", 64'(fifo_count), 64'd0);
        ahb_xfer(MBOX, 64'h55, 0, 1'b0);
        idle(3);
        chk("read_xfer", 64'(fifo_count), 64'd0);
        ahb_xfer(MBOX, 64'h0000_0000_0000_5600, 0, 1'b1);
        ahb_xfer(32'hD058_0001, 64'h0000_0000_0000_5600, 0, 1'b1);
        idle(2);
        chk("lane_mismatch", 64'(fifo_count), 64'd2);
        chk("lane0_of_56", 64'(char_data), 64'h00);
        char_ready = 1'b1;
        idle(1);
        char_ready = 1'b0;
        chk("lane1_data", 64'(char_data), 64'h56);
        while (cyc != 32'h1800) @(negedge core_clk);
        chk("pre_tmo_done", 64'(test_done), 64'd0);
        @(negedge core_clk);
        chk("tmo_done", 64'(test_done), 64'd1);
        chk("tmo_pass", 64'(test_pass), 64'd0);
        chk("tmo_flag", 64'(timeout), 64'd1);
        chk("tmo_dcyc", 64'(done_cycle), 64'h1800);
        chk("tmo_fifo_kept", 64'(char_valid), 64'd1);
        char_ready = 1'b1;
        idle(1);
        char_ready = 1'b0;
        chk("tmo_drain", 64'(fifo_count), 64'd0);

        // FAIL code
        @(negedge core_clk); reset_l = 1'b0;
        @(negedge core_clk); reset_l = 1'b1;
        ahb_xfer(MBOX, 64'h01, 0, 1'b1);
        idle(2);
        chk("fail_done", 64'(test_done), 64'd1);
        chk("fail_pass", 64'(test_pass), 64'd0);
        chk("fail_tmo", 64'(timeout), 64'd0);
        chk("fail_nopush", 64'(fifo_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
